adder: RTL and testbench



---
 rtl/adder.sv | 103 ++++++++++
 tb/tb_adder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/adder.sv
// Registered carry-lookahead adder: 4-bit lookahead groups feed a second-level
// lookahead unit, and {Cout, sum} is registered one clock after the inputs.
module adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] be_add_number,
    input  logic [WIDTH-1:0] add_number,
    input  logic             Cin,
    output logic [WIDTH-1:0] sum,
    output logic             Cout
);

    localparam int unsigned NG = WIDTH / 4;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG:0]      grp_c;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;

    // Expanded sum-of-products carry into group k from Cin and groups 0..k-1.
    function automatic logic group_carry(
        input logic [NG-1:0] gg,
        input logic [NG-1:0] pp,
        input logic          ci,
        input int            k
    );
        logic acc;
        logic prod;
        acc = 1'b0;
        for (int j = 0; j < k; j++) begin
            prod = gg[j];
            for (int m = j + 1; m < k; m++) begin
                prod = prod & pp[m];
            end
            acc = acc | prod;
        end
        prod = ci;
        for (int m = 0; m < k; m++) begin
            prod = prod & pp[m];
        end
        return acc | prod;
    endfunction

    assign g = be_add_number & add_number;
    assign p = be_add_number ^ add_number;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        localparam int unsigned B = 4 * k;

        assign c[B]     = grp_c[k];
        assign c[B + 1] = g[B]
                        | (p[B] & grp_c[k]);
        assign c[B + 2] = g[B + 1]
                        | (p[B + 1] & g[B])
                        | (p[B + 1] & p[B] & grp_c[k]);
        assign c[B + 3] = g[B + 2]
                        | (p[B + 2] & g[B + 1])
                        | (p[B + 2] & p[B + 1] & g[B])
                        | (p[B + 2] & p[B + 1] & p[B] & grp_c[k]);

        assign grp_g[k] = g[B + 3]
                        | (p[B + 3] & g[B + 2])
                        | (p[B + 3] & p[B + 2] & g[B + 1])
                        | (p[B + 3] & p[B + 2] & p[B + 1] & g[B]);
        assign grp_p[k] = p[B + 3] & p[B + 2] & p[B + 1] & p[B];
    end

    // Second-level lookahead; the top entry is the adder carry-out.
    always_comb begin
        grp_c = '0;
        for (int k = 0; k <= int'(NG); k++) begin
            grp_c[k] = group_carry(grp_g, grp_p, Cin, k);
        end
    end

    always_comb begin
        sum_d  = p ^ c;
        cout_d = grp_c[NG];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: a 4-bit and a 16-bit instance checked against
// plain integer addition, with directed tables, reset/latency sequences and random vectors.
module tb_adder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  a4, b4, s4;
    logic        ci4, co4;
    logic [15:0] a16, b16, s16;
    logic        ci16, co16;

    int n_checks = 0;
    int n_fail   = 0;

    adder #(.WIDTH(4)) u_add4 (
        .clk(clk), .rst_n(rst_n),
        .be_add_number(a4), .add_number(b4), .Cin(ci4),
        .sum(s4), .Cout(co4)
    );

    adder #(.WIDTH(16)) u_add16 (
        .clk(clk), .rst_n(rst_n),
        .be_add_number(a16), .add_number(b16), .Cin(ci16),
        .sum(s16), .Cout(co16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        is16;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] s;
        logic        co;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact unsigned addition of the three inputs.
    function automatic logic [16:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        int r;
        r = int'(a) + int'(b) + int'(ci);
        return 17'(r % 32);
    endfunction

    function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic ci);
        int r;
        r = int'(a) + int'(b) + int'(ci);
        return 17'(r);
    endfunction

    function automatic logic [16:0] out4();
        return 17'({co4, s4});
    endfunction

    function automatic logic [16:0] out16();
        return {co16, s16};
    endfunction

    initial begin
        vecs[0] = '{1'b0, 16'h0000, 16'h0008, 1'b0, 16'h0008, 1'b0};
        vecs[1] = '{1'b0, 16'h000F, 16'h0008, 1'b0, 16'h0007, 1'b1};
        vecs[2] = '{1'b0, 16'h000F, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[3] = '{1'b0, 16'h0005, 16'h000A, 1'b1, 16'h0000, 1'b1};
        vecs[4] = '{1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[5] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[6] = '{1'b1, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        vecs[7] = '{1'b1, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};

        // Reset holds outputs at zero despite all-ones inputs.
        rst_n = 1'b0;
        a4 = 4'hF;     b4 = 4'hF;     ci4 = 1'b1;
        a16 = 16'hFFFF; b16 = 16'hFFFF; ci16 = 1'b1;
        step();
        chk("reset_edge1_w4", out4(), 17'h0);
        chk("reset_edge1_w16", out16(), 17'h0);
        step();
        chk("reset_edge2_w4", out4(), 17'h0);
        chk("reset_edge2_w16", out16(), 17'h0);
        rst_n = 1'b1;
        step();
        chk("reset_release_w4", out4(), 17'h1F);
        chk("reset_release_w16", out16(), 17'h1FFFF);

        // Synchronous reset: a mid-cycle drop has no effect until the next edge.
        a4 = 4'h3; b4 = 4'h4; ci4 = 1'b0;
        step();
        chk("pre_sync_reset", out4(), 17'h07);
        rst_n = 1'b0;
        #2;
        chk("sync_reset_hold", out4(), 17'h07);
        step();
        chk("sync_reset_edge", out4(), 17'h0);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is16) begin
                a16 = vecs[i].a; b16 = vecs[i].b; ci16 = vecs[i].ci;
            end else begin
                a4 = vecs[i].a[3:0]; b4 = vecs[i].b[3:0]; ci4 = vecs[i].ci;
            end
            step();
            if (vecs[i].is16)
                chk($sformatf("table_w16_%0d", i), out16(), {vecs[i].co, vecs[i].s});
            else
                chk($sformatf("table_w4_%0d", i), out4(), 17'({vecs[i].co, vecs[i].s[3:0]}));
        end

        // Back-to-back: one result per edge, outputs hold while inputs change.
        a4 = 4'h3; b4 = 4'h4; ci4 = 1'b0;
        step();
        chk("b2b_0", out4(), 17'h07);
        a4 = 4'h9; b4 = 4'h9; ci4 = 1'b1;
        #1;
        chk("b2b_hold", out4(), 17'h07);
        step();
        chk("b2b_1", out4(), 17'h13);
        a4 = 4'h0; b4 = 4'h0; ci4 = 1'b0;
        step();
        chk("b2b_2", out4(), 17'h00);

        // Exhaustive 4-bit.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            a4 = v[3:0]; b4 = v[7:4]; ci4 = v[8];
            step();
            chk($sformatf("exh_w4_%0d", i), out4(), ref4(v[3:0], v[7:4], v[8]));
        end

        // Random 16-bit.
        for (int i = 0; i < 10000; i++) begin
            logic [15:0] ra, rb;
            logic        rc;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            a16 = ra; b16 = rb; ci16 = rc;
            step();
            chk($sformatf("rand_w16_%0d", i), out16(), ref16(ra, rb, rc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
